fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter and flow controller for the 8-deep, 4-bit asynchronous FIFO. Shares the single FIFO write port between NREQ requesters in the wclk domain using round-robin, burst-limited grants. Tracks free FIFO space with a local credit counter, replenished by read-side credit pulses already synchronized into wclk, so no write is ever issued to a full FIFO. Drives the FIFO's write enable and write data directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 4, data width per requester
- DEPTH, 8, FIFO depth; initial and maximum credit count
- MAX_BURST, 4, maximum words accepted per grant (1..DEPTH)
- wclk  input  1  write-domain clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  per-requester valid; must hold with data until granted
- req_data  input  NREQ*DW  requester i data at bits [i*DW +: DW]
- gnt  output  NREQ  one-hot accept strobe, combinational; word accepted in the cycle gnt[i]=1
- credit_ret  input  1  one-cycle pulse per word read from FIFO, synchronized into wclk
- fifo_we  output  1  registered FIFO write enable
- fifo_wdata  output  DW  registered FIFO write data
- credits  output  $clog2(DEPTH)+1  current free-slot count
- ovf_err  output  1  sticky: credit_ret received with credits==DEPTH
- wr_count  output  16  accepted-word counter (see Configuration)

## Operation
- FSM states: IDLE, BURST. Registers: owner (index), last (index of previous owner), burst_cnt (0..MAX_BURST), credits.
- IDLE: gnt=0. If |req and credits>0: owner <= first requester with req=1 searching last+1, last+2, … wrapping modulo NREQ; burst_cnt <= 0; go BURST. Otherwise stay.
- BURST: accept = req[owner] && credits>0; gnt[owner]=accept, all other gnt bits 0.
- On accept: burst_cnt++; fifo_wdata <= req_data[owner]; fifo_we <= 1.
- Leave BURST to IDLE (last <= owner) when: req[owner]=0 in a BURST cycle, or accept with burst_cnt+1==MAX_BURST.
- credits==0 in BURST with req[owner]=1: stall, hold ownership, gnt=0, burst_cnt unchanged.
- Credit arithmetic: credits <= credits − accept + credit_ret; simultaneous accept and credit_ret → unchanged. credit_ret with credits==DEPTH and no accept: credits stay DEPTH, ovf_err <= 1 (cleared only by rst). Credit returned in cycle N usable from cycle N+1.
- fifo_we is 0 in every cycle not following an accept; fifo_wdata holds last written value.

## Timing
- Reset values: state IDLE, owner 0, last NREQ−1 (so requester 0 wins first), burst_cnt 0, credits DEPTH, fifo_we 0, fifo_wdata 0, ovf_err 0, wr_count 0, gnt 0.
- req rising at edge E → IDLE→BURST at E+1 → gnt earliest in cycle after E+1 (one dead cycle).
- Accept in cycle N → fifo_we=1, fifo_wdata valid in cycle N+1, credits decremented at same edge.
- Back-to-back: a single requester holding req streams MAX_BURST words on consecutive cycles, then one IDLE cycle before next grant.
- rst asserted mid-burst: immediate return to reset values; any word accepted in the same cycle is discarded (fifo_we forced 0).

## Configuration
- WR_ARB_STATS_EN defined: wr_count increments by 1 per accept, saturates at 16'hFFFF, resets to 0.
- Not defined: wr_count tied to 0, no counter logic synthesized; port remains present.

## Test plan
- Reset then req=4'b0001, data0=4'hA, after 1 IDLE cycle → gnt=4'b0001 one cycle, fifo_we=1 with fifo_wdata=4'hA next cycle, credits 8→7.
- All four req held continuously, MAX_BURST=4 → grant order 0,1,2,3,0 each with 4 consecutive gnt pulses, one idle cycle between bursts.
- Requester 2 streams 8 words with no credit_ret → credits reach 0, gnt stalls, no fifo_we; one credit_ret pulse → exactly one further word accepted next cycle.
- accept and credit_ret in same cycle at credits=3 → credits remain 3; credit_ret at credits=8 → credits 8, ovf_err=1 and sticky.
- req[1] dropped mid-burst after 2 words with req[3] pending → return to IDLE, next grant to requester 3.
- rst pulsed during active burst → fifo_we=0 immediately, credits=8, state IDLE; with WR_ARB_STATS_EN, 10 accepts → wr_count=10, rst → 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Write-side round-robin, burst-limited arbiter with credit-based flow control for the async FIFO.
// Optional accepted-word counter enabled by defining WR_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin when credits are available
// BURST | owner streams up to MAX_BURST words, stalling while credits are zero
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    wclk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    credit_ret,
  output logic                    fifo_we,
  output logic [DW-1:0]           fifo_wdata,
  output logic [$clog2(DEPTH):0]  credits,
  output logic                    ovf_err,
  output logic [15:0]             wr_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   owner, owner_nx, last, last_nx, rr_pick, rr_idx;
  logic [BW-1:0]   burst_cnt, burst_cnt_nx;
  logic [DW-1:0]   owner_data;
  logic            accept, burst_end, have_credit;

  assign have_credit = (credits != '0);
  assign burst_end   = (burst_cnt == BW'(MAX_BURST - 1));

  // Scan from farthest to nearest so the requester closest after last wins.
  always_comb begin
    rr_pick = last;
    rr_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_idx = IW'((int'(last) + k) % NREQ);
      if (req[rr_idx]) rr_pick = rr_idx;
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) owner_data = req_data[i*DW +: DW];
    end
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      burst_cnt <= burst_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    last_nx      = last;
    burst_cnt_nx = burst_cnt;
    case (state)
      IDLE: begin
        if (|req && have_credit) begin
          owner_nx     = rr_pick;
          burst_cnt_nx = '0;
          state_nx     = BURST;
        end
      end
      BURST: begin
        if (!req[owner]) begin
          state_nx = IDLE;
          last_nx  = owner;
        end else if (accept) begin
          burst_cnt_nx = burst_cnt + BW'(1);
          if (burst_end) begin
            state_nx = IDLE;
            last_nx  = owner;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt    = '0;
    accept = 1'b0;
    if (state == BURST && req[owner] && have_credit) begin
      accept     = 1'b1;
      gnt[owner] = 1'b1;
    end
  end

  // Simultaneous accept and credit return cancel out.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      fifo_we    <= 1'b0;
      fifo_wdata <= '0;
      credits    <= CW'(DEPTH);
      ovf_err    <= 1'b0;
    end else begin
      fifo_we <= accept;
      if (accept) fifo_wdata <= owner_data;
      if (accept && !credit_ret) begin
        credits <= credits - CW'(1);
      end else if (!accept && credit_ret) begin
        if (credits == CW'(DEPTH)) ovf_err <= 1'b1;
        else                       credits <= credits + CW'(1);
      end
    end
  end

`ifdef WR_ARB_STATS_EN
  always_ff @(posedge wclk or posedge rst) begin
    if (rst)                                wr_count <= '0;
    else if (accept && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
  end
`else
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random requester traffic
// checked against a transaction-level model of grants, credits and written words.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4, DW = 4, DEPTH = 8, MAX_BURST = 4;

  logic        wclk, rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        credit_ret;
  logic        fifo_we;
  logic [3:0]  fifo_wdata;
  logic [3:0]  credits;
  logic        ovf_err;
  logic [15:0] wr_count;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .credit_ret(credit_ret), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata),
    .credits(credits), .ovf_err(ovf_err), .wr_count(wr_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];

  // reference model
  bit m_busy;
  int m_owner, m_last, m_cnt, m_credits, m_wr;
  bit m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge wclk) begin
    if (!rst && fifo_we) begin
      if (sb.size() == 0) chk("fifo_we_unexpected", 1, 0);
      else                chk("fifo_wdata", int'(fifo_wdata), sb.pop_front());
    end
  end

  function automatic int exp_wr();
`ifdef WR_ARB_STATS_EN
    return m_wr;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
    m_credits = DEPTH; m_wr = 0; m_ovf = 0;
    sb.delete();
  endtask

  // One cycle: drive inputs, check gnt, advance model, cross the edge, check registers.
  task automatic step(input logic [3:0] r, input logic [15:0] d, input logic cr, output int g);
    logic [3:0] exp_g;
    bit acc;
    req = r; req_data = d; credit_ret = cr;
    #1;
    exp_g = '0; acc = 0; g = -1;
    if (m_busy && r[m_owner] && m_credits > 0) begin
      exp_g[m_owner] = 1'b1; acc = 1; g = m_owner;
    end
    chk("gnt", int'(gnt), int'(exp_g));
    if (acc) sb.push_back(int'(d[m_owner*4 +: 4]));
    if (!m_busy) begin
      if (r != 0 && m_credits > 0) begin
        for (int k = NREQ; k >= 1; k--)
          if (r[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
        m_busy = 1; m_cnt = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (acc) begin
      m_cnt++;
      if (m_cnt == MAX_BURST) begin m_busy = 0; m_last = m_owner; end
    end
    if (acc && !cr) m_credits--;
    else if (!acc && cr) begin
      if (m_credits == DEPTH) m_ovf = 1;
      else                    m_credits++;
    end
    if (acc && m_wr != 16'hFFFF) m_wr++;
    @(posedge wclk); #1;
    chk("credits", int'(credits), m_credits);
    chk("ovf_err", int'(ovf_err), int'(m_ovf));
    chk("wr_count", int'(wr_count), exp_wr());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_fifo_we", int'(fifo_we), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_credits", int'(credits), DEPTH);
    chk("rst_wr_count", int'(wr_count), 0);
    model_reset();
    @(posedge wclk); #1;
    rst = 1'b0;
  endtask

  int g, cnt;
  int exp_owner;
  int pend [4];
  logic [3:0] dat [4];
  logic [15:0] d;
  logic [3:0] r;

  initial begin
    rst = 1'b1; req = '0; req_data = '0; credit_ret = 1'b0;
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_fifo_we", int'(fifo_we), 0);
    chk("reset_fifo_wdata", int'(fifo_wdata), 0);
    chk("reset_credits", int'(credits), DEPTH);
    chk("reset_ovf", int'(ovf_err), 0);
    chk("reset_wr_count", int'(wr_count), 0);
    rst = 1'b0;

    // single word from requester 0
    step(4'b0001, 16'h000A, 1'b0, g);
    chk("t1_dead_cycle", g, -1);
    step(4'b0001, 16'h000A, 1'b0, g);
    chk("t1_gnt_owner", g, 0);
    chk("t1_we", int'(fifo_we), 1);
    chk("t1_wdata", int'(fifo_wdata), 'hA);
    step(4'b0000, 16'h0000, 1'b0, g);
    chk("t1_we_drop", int'(fifo_we), 0);
    chk("t1_credits", int'(credits), 7);

    // all requesters held: bursts of 4 in order 0,1,2,3,0 with one idle cycle between
    do_reset();
    for (int c = 0; c < 25; c++) begin
      d = 16'($urandom);
      step(4'b1111, d, m_credits < DEPTH, g);
      if (c == 0 || (c - 1) % 5 == 4) exp_owner = -1;
      else                            exp_owner = ((c - 1) / 5) % 4;
      chk("rr_order", g, exp_owner);
    end
    repeat (2) step(4'b0000, 16'h0, 1'b0, g);

    // requester 2 drains all credits, then one credit buys exactly one word
    do_reset();
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(4'b0100, 16'($urandom), 1'b0, g);
      if (g >= 0) cnt++;
    end
    chk("drain_words", cnt, 8);
    chk("drain_credits", int'(credits), 0);
    step(4'b0100, 16'($urandom), 1'b1, g);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(4'b0100, 16'($urandom), 1'b0, g);
      if (g >= 0) cnt++;
    end
    chk("one_word_per_credit", cnt, 1);
    step(4'b0100, 16'($urandom), 1'b1, g);
    step(4'b0100, 16'($urandom), 1'b0, g);
    chk("burst_stall_resume", g, 2);
    repeat (2) step(4'b0000, 16'h0, 1'b0, g);

    // simultaneous accept and credit return, then overflow
    do_reset();
    for (int c = 0; c < 7; c++) step(4'b0001, 16'($urandom), 1'b0, g);
    chk("pre_simul_credits", int'(credits), 3);
    step(4'b0001, 16'($urandom), 1'b1, g);
    chk("simul_gnt", g, 0);
    chk("simul_credits", int'(credits), 3);
    for (int c = 0; c < 5; c++) step(4'b0000, 16'h0, 1'b1, g);
    chk("full_credits", int'(credits), DEPTH);
    chk("no_ovf_yet", int'(ovf_err), 0);
    step(4'b0000, 16'h0, 1'b1, g);
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_credits", int'(credits), DEPTH);
    repeat (3) step(4'b0000, 16'h0, 1'b0, g);
    chk("ovf_sticky", int'(ovf_err), 1);

    // owner drops request mid-burst, pending requester 3 wins next
    do_reset();
    step(4'b1010, 16'h5050, 1'b0, g);
    step(4'b1010, 16'h5060, 1'b0, g);
    chk("drop_first_owner", g, 1);
    step(4'b1010, 16'h5070, 1'b0, g);
    step(4'b1000, 16'h5000, 1'b0, g);
    chk("drop_no_gnt", g, -1);
    step(4'b1000, 16'h5000, 1'b0, g);
    step(4'b1000, 16'h5000, 1'b0, g);
    chk("drop_next_owner", g, 3);
    repeat (2) step(4'b0000, 16'h0, 1'b0, g);

    // reset mid-burst and accepted-word counter
    do_reset();
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 10; c++) begin
      step(4'b0001, 16'($urandom), m_credits < DEPTH, g);
      if (g >= 0) cnt++;
    end
    chk("stats_accepts", cnt, 10);
    chk("stats_wr_count", int'(wr_count), exp_wr());
`ifdef WR_ARB_STATS_EN
    chk("stats_wr_count_10", int'(wr_count), 10);
`endif
    req = 4'b0001;
    #1;
    chk("mid_burst_gnt", int'(gnt), 1);
    chk("mid_burst_we", int'(fifo_we), 1);
    do_reset();
    chk("post_rst_credits", int'(credits), DEPTH);

    // random traffic
    for (int i = 0; i < 4; i++) begin pend[i] = 0; dat[i] = 4'($urandom); end
    for (int c = 0; c < 600; c++) begin
      r = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 7) == 0) pend[i] = $urandom_range(1, 6);
        r[i] = (pend[i] > 0);
        d[i*4 +: 4] = dat[i];
      end
      step(r, d, (m_credits < DEPTH) && ($urandom_range(0, 1) == 1), g);
      if (g >= 0) begin
        pend[g]--;
        dat[g] = 4'($urandom);
      end
    end
    repeat (3) step(4'b0000, 16'h0, 1'b0, g);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
